// File: rtl/touch_pad_decoder.sv
// touch_pad_decoder
// Synchronises and debounces active-low touch pads, then turns each pad's
// debounced level into PRESS / RELEASE / LONG events. Every pad owns a
// one-entry pending slot. A single output register drains the slots in
// fixed index order onto a valid/ready stream.
//
// Stream handshake (evt_valid / evt_ready):
//   An event transfers on the rising clk edge where evt_valid and evt_ready
//   are both high. Once evt_valid rises, evt_pad and evt_code stay constant
//   until that transfer. evt_valid never drops without a transfer, except on
//   rst. The output register reloads whenever it is empty or transferring, so
//   with evt_ready held high one event per cycle can flow.
module touch_pad_decoder #(
    parameter int NUM_PADS        = 2,
    parameter int DEBOUNCE_CYCLES = 48000,
    parameter int LONG_CYCLES     = 24000000
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic [NUM_PADS-1:0]                               pad_n,
    output logic [NUM_PADS-1:0]                               pressed,
    output logic                                              evt_valid,
    input  logic                                              evt_ready,
    output logic [((NUM_PADS > 1) ? $clog2(NUM_PADS) : 1)-1:0] evt_pad,
    output logic [1:0]                                        evt_code,
    output logic                                              evt_overrun,
    output logic [2*NUM_PADS-1:0]                             dbg_state
);

    localparam int PAD_W = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;
    localparam int CNT_W = $clog2(LONG_CYCLES + 1);

    localparam logic [CNT_W-1:0] DEB_C   = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] LONG_C  = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] LONG_M1 = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    localparam logic [1:0] CODE_PRESS   = 2'b01;
    localparam logic [1:0] CODE_RELEASE = 2'b10;
    localparam logic [1:0] CODE_LONG    = 2'b11;

    typedef enum logic [1:0] {
        ST_RELEASED     = 2'b00,
        ST_PRESS_PEND   = 2'b01,
        ST_PRESSED      = 2'b10,
        ST_RELEASE_PEND = 2'b11
    } pad_state_e;

    // synchroniser
    logic [NUM_PADS-1:0] sync1_q;
    logic [NUM_PADS-1:0] sync2_q;
    logic [NUM_PADS-1:0] s;

    // per-pad debounce FSM
    pad_state_e          state_q [NUM_PADS];
    pad_state_e          state_d [NUM_PADS];
    logic [CNT_W-1:0]    cnt_q   [NUM_PADS];
    logic [CNT_W-1:0]    cnt_d   [NUM_PADS];
    logic [CNT_W-1:0]    rcnt_q  [NUM_PADS];
    logic [CNT_W-1:0]    rcnt_d  [NUM_PADS];
    logic [NUM_PADS-1:0] long_done_q;
    logic [NUM_PADS-1:0] long_done_d;
    logic [NUM_PADS-1:0] pressed_q;
    logic [NUM_PADS-1:0] pressed_d;

    // event produced by each FSM this cycle
    logic [NUM_PADS-1:0] q_valid;
    logic [1:0]          q_code [NUM_PADS];

    // pending slots
    logic [NUM_PADS-1:0] slot_full_q;
    logic [NUM_PADS-1:0] slot_full_d;
    logic [1:0]          slot_code_q [NUM_PADS];
    logic [1:0]          slot_code_d [NUM_PADS];
    logic [NUM_PADS-1:0] drain;

    // output register
    logic                load;
    logic                sel_found;
    logic [PAD_W-1:0]    sel_idx;
    logic [1:0]          sel_code;
    logic                evt_valid_q;
    logic                evt_valid_d;
    logic [PAD_W-1:0]    evt_pad_q;
    logic [PAD_W-1:0]    evt_pad_d;
    logic [1:0]          evt_code_q;
    logic [1:0]          evt_code_d;
    logic                overrun_q;
    logic                overrun_d;

    assign s = ~sync2_q;

    // two-flop synchroniser; reset value is "pin high" (not touched)
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= pad_n;
            sync2_q <= sync1_q;
        end
    end

    // per-pad FSM next state, counters and event generation
    always_comb begin
        for (int i = 0; i < NUM_PADS; i++) begin
            state_d[i]     = state_q[i];
            cnt_d[i]       = cnt_q[i];
            rcnt_d[i]      = rcnt_q[i];
            long_done_d[i] = long_done_q[i];
            pressed_d[i]   = pressed_q[i];
            q_valid[i]     = 1'b0;
            q_code[i]      = 2'b00;

            // Hold-time counter keeps running through a pending release so a
            // bounce on release does not restart the LONG timer.
            if (state_q[i] == ST_PRESSED || state_q[i] == ST_RELEASE_PEND) begin
                if (cnt_q[i] != LONG_C) begin
                    cnt_d[i] = cnt_q[i] + ONE_C;
                end
                if (cnt_q[i] == LONG_M1 && !long_done_q[i]) begin
                    q_valid[i]     = 1'b1;
                    q_code[i]      = CODE_LONG;
                    long_done_d[i] = 1'b1;
                end
            end

            case (state_q[i])
                ST_RELEASED: begin
                    if (s[i]) begin
                        state_d[i] = ST_PRESS_PEND;
                        cnt_d[i]   = ONE_C;
                    end
                end
                ST_PRESS_PEND: begin
                    if (!s[i]) begin
                        state_d[i] = ST_RELEASED;
                    end else if (cnt_q[i] == DEB_C) begin
                        state_d[i]     = ST_PRESSED;
                        pressed_d[i]   = 1'b1;
                        q_valid[i]     = 1'b1;
                        q_code[i]      = CODE_PRESS;
                        cnt_d[i]       = '0;
                        long_done_d[i] = 1'b0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + ONE_C;
                    end
                end
                ST_PRESSED: begin
                    if (!s[i]) begin
                        state_d[i] = ST_RELEASE_PEND;
                        rcnt_d[i]  = ONE_C;
                    end
                end
                ST_RELEASE_PEND: begin
                    if (s[i]) begin
                        state_d[i] = ST_PRESSED;
                    end else if (rcnt_q[i] == DEB_C) begin
                        // A LONG maturing on the same cycle is superseded:
                        // the press has ended, so RELEASE takes the slot.
                        state_d[i]   = ST_RELEASED;
                        pressed_d[i] = 1'b0;
                        q_valid[i]   = 1'b1;
                        q_code[i]    = CODE_RELEASE;
                    end else begin
                        rcnt_d[i] = rcnt_q[i] + ONE_C;
                    end
                end
                default: begin
                    state_d[i] = ST_RELEASED;
                end
            endcase
        end
    end

    // per-pad FSM state and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PADS; i++) begin
                state_q[i] <= ST_RELEASED;
                cnt_q[i]   <= '0;
                rcnt_q[i]  <= '0;
            end
            long_done_q <= '0;
            pressed_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_PADS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                rcnt_q[i]  <= rcnt_d[i];
            end
            long_done_q <= long_done_d;
            pressed_q   <= pressed_d;
        end
    end

    // fixed-priority pick of the lowest-index full slot for the output register
    always_comb begin
        load      = ~evt_valid_q | evt_ready;
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_code  = 2'b00;
        drain     = '0;
        for (int i = 0; i < NUM_PADS; i++) begin
            if (slot_full_q[i] && !sel_found) begin
                sel_found = 1'b1;
                sel_idx   = PAD_W'(i);
                sel_code  = slot_code_q[i];
                drain[i]  = load;
            end
        end
    end

    // slot fill/drain and overrun detection
    always_comb begin
        overrun_d = overrun_q;
        for (int i = 0; i < NUM_PADS; i++) begin
            slot_full_d[i] = slot_full_q[i];
            slot_code_d[i] = slot_code_q[i];
            if (drain[i]) begin
                // draining frees the slot for an event arriving this cycle
                slot_full_d[i] = q_valid[i];
                if (q_valid[i]) begin
                    slot_code_d[i] = q_code[i];
                end
            end else if (q_valid[i]) begin
                if (slot_full_q[i]) begin
                    overrun_d = 1'b1;
                end else begin
                    slot_full_d[i] = 1'b1;
                    slot_code_d[i] = q_code[i];
                end
            end
        end
    end

    // output register next value: reload when empty or transferring
    always_comb begin
        evt_valid_d = evt_valid_q;
        evt_pad_d   = evt_pad_q;
        evt_code_d  = evt_code_q;
        if (load) begin
            evt_valid_d = sel_found;
            if (sel_found) begin
                evt_pad_d  = sel_idx;
                evt_code_d = sel_code;
            end
        end
    end

    // slot and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_full_q <= '0;
            for (int i = 0; i < NUM_PADS; i++) begin
                slot_code_q[i] <= 2'b00;
            end
            evt_valid_q <= 1'b0;
            evt_pad_q   <= '0;
            evt_code_q  <= 2'b00;
            overrun_q   <= 1'b0;
        end else begin
            slot_full_q <= slot_full_d;
            for (int i = 0; i < NUM_PADS; i++) begin
                slot_code_q[i] <= slot_code_d[i];
            end
            evt_valid_q <= evt_valid_d;
            evt_pad_q   <= evt_pad_d;
            evt_code_q  <= evt_code_d;
            overrun_q   <= overrun_d;
        end
    end

    // debug view of every pad FSM, two bits per pad
    always_comb begin
        dbg_state = '0;
        for (int i = 0; i < NUM_PADS; i++) begin
            dbg_state[2*i +: 2] = state_q[i];
        end
    end

    assign pressed     = pressed_q;
    assign evt_valid   = evt_valid_q;
    assign evt_pad     = evt_pad_q;
    assign evt_code    = evt_code_q;
    assign evt_overrun = overrun_q;

endmodule
